// File: rtl/run_control.sv
// Front-panel run/halt controller: debounces START/STOP/STEP and drives HALTN to the pulse timer,
// halting only on machine-cycle boundaries. Define RUN_CONTROL_BREAKPOINT_EN to add a PC breakpoint.
module run_control #(
    parameter int DB_CYCLES   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       INCLK,
    input  logic       RST,
    input  logic       START_BTN,
    input  logic       STOP_BTN,
    input  logic       STEP_BTN,
    input  logic       HLT,
    input  logic       CYCLE_END,
    output logic       HALTN,
    output logic       RUN_LED,
    output logic [1:0] STATE
`ifdef RUN_CONTROL_BREAKPOINT_EN
    ,
    input  logic [7:0] PC,
    input  logic [7:0] BP_ADDR,
    input  logic       BP_ARM,
    output logic       BP_HIT
`endif
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic       haltn_q;
    logic       run_led_q;
    logic [2:0] btn_raw;
    logic [2:0] btn_pulse;
    logic       start_p, stop_p, step_p;
    logic       stop_req;
    logic       bp_stop;

    assign btn_raw = {STEP_BTN, STOP_BTN, START_BTN};

    // One synchroniser + debouncer per button; the pulse fires on the press edge only.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic [SYNC_STAGES-1:0] sync_q;
            logic [CW-1:0]          cnt_q;
            logic                   db_q;
            logic                   pulse_q;

            always_ff @(posedge INCLK) begin
                if (RST) begin
                    sync_q  <= '0;
                    cnt_q   <= '0;
                    db_q    <= 1'b0;
                    pulse_q <= 1'b0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[gi]};
                    if (sync_q[SYNC_STAGES-1] == db_q) begin
                        cnt_q   <= '0;
                        pulse_q <= 1'b0;
                    end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        db_q    <= ~db_q;
                        pulse_q <= ~db_q;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        pulse_q <= 1'b0;
                    end
                end
            end

            assign btn_pulse[gi] = pulse_q;
        end
    endgenerate

    assign start_p = btn_pulse[0];
    assign stop_p  = btn_pulse[1];
    assign step_p  = btn_pulse[2];

`ifdef RUN_CONTROL_BREAKPOINT_EN
    logic bp_hit_q, bp_hit_d;

    assign bp_stop = BP_ARM && (PC == BP_ADDR);

    // A new hit in the same cycle as a start press still leaves the flag set.
    always_comb begin
        bp_hit_d = bp_hit_q;
        if (start_p) bp_hit_d = 1'b0;
        if (state_q == ST_RUN && bp_stop) bp_hit_d = 1'b1;
    end

    always_ff @(posedge INCLK) begin
        if (RST) bp_hit_q <= 1'b0;
        else     bp_hit_q <= bp_hit_d;
    end

    assign BP_HIT = bp_hit_q;
`else
    assign bp_stop = 1'b0;
`endif

    assign stop_req = stop_p || HLT || bp_stop;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (start_p)     state_d = ST_RUN;
                else if (step_p) state_d = ST_STEP;
            end
            ST_RUN: begin
                if (stop_req) state_d = CYCLE_END ? ST_HALT : ST_DRAIN;
            end
            ST_STEP: begin
                if (CYCLE_END)          state_d = ST_HALT;
                else if (stop_p || HLT) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (CYCLE_END) state_d = ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Outputs are registered from the next state so they track STATE exactly.
    always_ff @(posedge INCLK) begin
        if (RST) begin
            state_q   <= ST_HALT;
            haltn_q   <= 1'b0;
            run_led_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            haltn_q   <= (state_d != ST_HALT);
            run_led_q <= (state_d == ST_RUN);
        end
    end

    assign HALTN   = haltn_q;
    assign RUN_LED = run_led_q;
    assign STATE   = state_q;

endmodule

// File: tb/tb_run_control.sv
// Randomised self-checking bench for run_control against a cycle-level behavioural model.
module tb_run_control;

    localparam int DB   = 4;
    localparam int SYNC = 2;
    localparam int S_HALT = 0, S_RUN = 1, S_STEP = 2, S_DRAIN = 3;

    logic       INCLK = 1'b0;
    logic       RST = 1'b1;
    logic       START_BTN = 1'b0, STOP_BTN = 1'b0, STEP_BTN = 1'b0;
    logic       HLT = 1'b0, CYCLE_END = 1'b0;
    logic       HALTN, RUN_LED;
    logic [1:0] STATE;
`ifdef RUN_CONTROL_BREAKPOINT_EN
    logic [7:0] PC = 8'h00, BP_ADDR = 8'h12;
    logic       BP_ARM = 1'b0;
    logic       BP_HIT;
`endif

    run_control #(.DB_CYCLES(DB), .SYNC_STAGES(SYNC)) dut (
        .INCLK(INCLK), .RST(RST),
        .START_BTN(START_BTN), .STOP_BTN(STOP_BTN), .STEP_BTN(STEP_BTN),
        .HLT(HLT), .CYCLE_END(CYCLE_END),
        .HALTN(HALTN), .RUN_LED(RUN_LED), .STATE(STATE)
`ifdef RUN_CONTROL_BREAKPOINT_EN
        , .PC(PC), .BP_ADDR(BP_ADDR), .BP_ARM(BP_ARM), .BP_HIT(BP_HIT)
`endif
    );

    always #5 INCLK = ~INCLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw history per button, run-length debounce, transition table.
    int m_edge = 0;
    int m_last_rst = 0;
    int m_hist [3][8];
    int m_db   [3];
    int m_run  [3];
    int m_pulse[3];
    int m_state = S_HALT;
    int m_bp_hit = 0;

    function automatic int raw_level(input int b);
        case (b)
            0: return int'(START_BTN);
            1: return int'(STOP_BTN);
            default: return int'(STEP_BTN);
        endcase
    endfunction

    task automatic model_step();
        int nxt, lev, req, bp;
        m_edge++;
        for (int b = 0; b < 3; b++) m_hist[b][m_edge % 8] = raw_level(b);
        if (RST) begin
            m_last_rst = m_edge;
            m_state = S_HALT;
            m_bp_hit = 0;
            for (int b = 0; b < 3; b++) begin
                m_db[b] = 0; m_run[b] = 0; m_pulse[b] = 0;
            end
            return;
        end
        bp = 0;
`ifdef RUN_CONTROL_BREAKPOINT_EN
        bp = (BP_ARM && PC == BP_ADDR) ? 1 : 0;
        if (m_pulse[0] != 0) m_bp_hit = 0;
        if (m_state == S_RUN && bp != 0) m_bp_hit = 1;
`endif
        req = (m_pulse[1] != 0 || HLT || bp != 0) ? 1 : 0;
        nxt = m_state;
        case (m_state)
            S_HALT:  if (m_pulse[0] != 0) nxt = S_RUN; else if (m_pulse[2] != 0) nxt = S_STEP;
            S_RUN:   if (req != 0) nxt = CYCLE_END ? S_HALT : S_DRAIN;
            S_STEP:  if (CYCLE_END) nxt = S_HALT; else if (m_pulse[1] != 0 || HLT) nxt = S_DRAIN;
            default: if (CYCLE_END) nxt = S_HALT;
        endcase
        m_state = nxt;
        for (int b = 0; b < 3; b++) begin
            lev = (m_edge - SYNC > m_last_rst) ? m_hist[b][(m_edge - SYNC) % 8] : 0;
            m_pulse[b] = 0;
            if (lev != m_db[b]) begin
                m_run[b]++;
                if (m_run[b] == DB) begin
                    m_db[b] = lev;
                    m_run[b] = 0;
                    m_pulse[b] = lev;
                end
            end else begin
                m_run[b] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge INCLK);
        model_step();
        @(negedge INCLK);
        check_eq("state", {6'd0, STATE}, 8'(m_state));
        check_eq("haltn", {7'd0, HALTN}, (m_state != S_HALT) ? 8'd1 : 8'd0);
        check_eq("run_led", {7'd0, RUN_LED}, (m_state == S_RUN) ? 8'd1 : 8'd0);
`ifdef RUN_CONTROL_BREAKPOINT_EN
        check_eq("bp_hit", {7'd0, BP_HIT}, 8'(m_bp_hit));
`endif
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: START_BTN = v;
            1: STOP_BTN = v;
            default: STEP_BTN = v;
        endcase
    endtask

    task automatic press(input int b, input int hold, input int after);
        set_btn(b, 1'b1);
        repeat (hold) tick();
        set_btn(b, 1'b0);
        repeat (after) tick();
    endtask

    initial begin
        int cnt, hold_left[3], ce_left;

        // Reset and idle.
        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        repeat (100) tick();
        check_eq("idle_state", {6'd0, STATE}, 8'd0);
        $display("[TB] reset/idle done, state=%0d", STATE);

        // Start press: must reach RUN within 7 cycles of the press.
        START_BTN = 1'b1;
        cnt = 0;
        while (STATE != 2'd1 && cnt < 20) begin tick(); cnt++; end
        check_eq("start_latency_ok", (cnt <= 7) ? 8'd1 : 8'd0, 8'd1);
        repeat (20 - cnt) tick();
        START_BTN = 1'b0;
        repeat (10) tick();
        check_eq("start_run_led", {7'd0, RUN_LED}, 8'd1);
        $display("[TB] start press done, state=%0d after %0d cycles", STATE, cnt);

        // Bouncing stop must be filtered.
        for (int i = 0; i < 12; i++) begin
            STOP_BTN = ((i / 2) % 2 == 0);
            tick();
        end
        STOP_BTN = 1'b0;
        repeat (10) tick();
        check_eq("bounce_state", {6'd0, STATE}, 8'd1);
        $display("[TB] bounce done, state=%0d", STATE);

        // Real stop: drain until the next cycle end.
        STOP_BTN = 1'b1;
        cnt = 0;
        while (m_state != S_DRAIN && cnt < 30) begin tick(); cnt++; end
        check_eq("drain_reached", {6'd0, STATE}, 8'd3);
        repeat (2) tick();
        check_eq("drain_hold", {6'd0, STATE}, 8'd3);
        CYCLE_END = 1'b1;
        tick();
        CYCLE_END = 1'b0;
        check_eq("stop_halt_state", {6'd0, STATE}, 8'd0);
        check_eq("stop_halt_haltn", {7'd0, HALTN}, 8'd0);
        STOP_BTN = 1'b0;
        repeat (10) tick();
        $display("[TB] stop/drain done, state=%0d", STATE);

        // Single step with a free-running cycle end every 6 cycles.
        STEP_BTN = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            CYCLE_END = (i % 6 == 5);
            if (i == 12) STEP_BTN = 1'b0;
            tick();
            if (HALTN) cnt++;
        end
        CYCLE_END = 1'b0;
        check_eq("step_one_cycle", (cnt >= 1 && cnt <= 6) ? 8'd1 : 8'd0, 8'd1);
        check_eq("step_end_state", {6'd0, STATE}, 8'd0);
        $display("[TB] step done, haltn high for %0d cycles", cnt);

        // HLT coinciding with cycle end halts directly.
        press(0, 10, 5);
        check_eq("hlt_pre_run", {6'd0, STATE}, 8'd1);
        HLT = 1'b1;
        CYCLE_END = 1'b1;
        tick();
        HLT = 1'b0;
        CYCLE_END = 1'b0;
        check_eq("hlt_direct_halt", {6'd0, STATE}, 8'd0);
        repeat (5) tick();
        $display("[TB] hlt done, state=%0d", STATE);

`ifdef RUN_CONTROL_BREAKPOINT_EN
        press(0, 10, 5);
        BP_ARM = 1'b1; BP_ADDR = 8'h12; PC = 8'h12;
        tick();
        PC = 8'h13;
        repeat (3) tick();
        CYCLE_END = 1'b1;
        tick();
        CYCLE_END = 1'b0;
        BP_ARM = 1'b0;
        check_eq("bp_hit_set", {7'd0, BP_HIT}, 8'd1);
        check_eq("bp_halt_state", {6'd0, STATE}, 8'd0);
        repeat (5) tick();
        $display("[TB] breakpoint done, bp_hit=%0d", BP_HIT);
`endif

        // Reset mid-RUN halts immediately.
        press(0, 10, 5);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_eq("rst_mid_run", {6'd0, STATE}, 8'd0);
        repeat (5) tick();
        $display("[TB] reset mid-run done, state=%0d", STATE);

        // Random phase: mixed bounces and genuine presses.
        for (int b = 0; b < 3; b++) hold_left[b] = 0;
        ce_left = 5;
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold_left[b] == 0) begin
                    set_btn(b, ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
                    hold_left[b] = $urandom_range(1, 14);
                end else begin
                    hold_left[b]--;
                end
            end
            if (ce_left == 0) begin
                CYCLE_END = 1'b1;
                ce_left = $urandom_range(3, 8);
            end else begin
                CYCLE_END = 1'b0;
                ce_left--;
            end
            HLT = ($urandom_range(0, 40) == 0);
            RST = ($urandom_range(0, 500) == 0);
`ifdef RUN_CONTROL_BREAKPOINT_EN
            PC = 8'($urandom_range(8'h10, 8'h30));
            if ($urandom_range(0, 50) == 0) BP_ARM = ~BP_ARM;
`endif
            tick();
        end
        RST = 1'b0;
        $display("[TB] random phase done at edge %0d", m_edge);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
